// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: FSM state encoding, digit limits,
// and the run/pause transition taken on a start_stop press.
// Latency: n/a (types and constants only). Backpressure: n/a.
package bcd_stopwatch_pkg;

  localparam int DIGIT_W = 4;

  // Per-digit wrap points. Minutes reuse the seconds limits (M9:59 style wrap to 00).
  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = SEC_ONES_MAX;
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = SEC_TENS_MAX;

  // 2'd3 is never produced; it behaves exactly like IDLE if it ever appears.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  // A press pauses a running watch and otherwise (idle, paused, unused code) starts it.
  function automatic state_t next_on_press(input state_t s);
    case (s)
      ST_RUNNING: return ST_PAUSED;
      default:    return ST_RUNNING;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch chain: counts 0..MAX on inc, wraps to 0 and carries.
// Latency: q updates on the clk edge after inc; carry is combinational (inc & q==MAX).
// Backpressure: none; every inc is accepted in the cycle it is presented.
//
// Ports:
//   clk, reset (async, active-high), clr (sync zero, priority over inc),
//   inc (advance one count), q (current BCD digit), carry (inc arriving at MAX).
module bcd_digit_counter
  import bcd_stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = SEC_ONES_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  assign carry = inc & (q == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      // >= rather than == so an out-of-range value can never persist.
      q <= (q >= MAX) ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch core: run/pause FSM, button edge detect, seconds prescaler, BCD digit chain.
// Latency: press sampled at edge N shows on running after edge N; digits move on the tick edge.
// Backpressure: none; button levels are sampled every cycle, clear has priority over start_stop.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   start_stop        debounced button level, rising edge toggles run/pause
//   clear             synchronous clear level, returns to IDLE with 00:00
//   digit0..digit3    seconds ones, seconds tens, minutes ones, minutes tens (BCD)
//   running           high while in RUNNING
//   rollover          one-cycle pulse on the 59:59 -> 00:00 wrap
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               clear,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic               running,
  output logic               rollover
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  state_t               state;
  logic                 btn_q;
  logic [PRESC_W-1:0]   presc;
  logic                 press;
  logic                 tick;
  logic                 carry_s0;
  logic                 carry_s1;
  logic                 carry_m0;
  logic                 carry_m1;

  // btn_q resets high so a button held through reset needs a release before it counts.
  assign press = start_stop & ~btn_q;

  // A press leaving RUNNING and a clear both win over the second boundary.
  assign tick = (state == ST_RUNNING) & (presc == PRESC_LAST) & ~press & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      btn_q    <= 1'b1;
      presc    <= '0;
      running  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      btn_q    <= start_stop;
      // Last carry only fires at 59:59 with a tick, and tick is already masked by clear.
      rollover <= carry_m1;

      if (clear) begin
        state   <= ST_IDLE;
        presc   <= '0;
        running <= 1'b0;
      end else if (press) begin
        // Prescaler holds across the transition so a resume finishes the partial second.
        state   <= next_on_press(state);
        running <= (next_on_press(state) == ST_RUNNING);
      end else if (state == ST_RUNNING) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      end
    end
  end

  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (tick),
    .q     (digit0),
    .carry (carry_s0)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (carry_s0),
    .q     (digit1),
    .carry (carry_s1)
  );

  bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (carry_s1),
    .q     (digit2),
    .carry (carry_m0)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (carry_m0),
    .q     (digit3),
    .carry (carry_m1)
  );

endmodule
